controle_acesso: RTL

Access-sequencing controller in front of the `maquina` code checker. It turns the raw `insere` key level into single-cycle digit strobes and counts `CODE_LEN` digits per attempt. After each attempt it samples the checker's match flag, then either grants a timed unlock or counts a failure. After `MAX_FAIL` consecutive failures it locks out input for `LOCK_CYCLES`; a 7-segment digit shows the attempts left or `L` while locked.

---
 rtl/controle_pkg.sv | 32 +++
 rtl/dec7seg.sv | 32 +++
 rtl/controle_acesso.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/controle_pkg.sv
// Shared types for the access-sequencing controller: state encoding,
// 7-segment patterns (bit 6 = A ... bit 0 = G) and a small sizing helper.
package controle_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_EVAL,
    S_OPEN,
    S_CLEAR,
    S_LOCKED
  } state_t;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;
  localparam logic [6:0] SEG_L = 7'b0001110;

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/dec7seg.sv
// Status digit decoder: val_i (0..9) or the lock glyph when lock_i.
// Ports: val_i[3:0], lock_i in; seg_o[6:0] = {A,B,C,D,E,F,G} out.
module dec7seg
  import controle_pkg::*;
(
  input  logic [3:0] val_i,
  input  logic       lock_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = '0;
    if (lock_i) begin
      seg_o = SEG_L;
    end else begin
      case (val_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/controle_acesso.sv
// Access sequencer in front of the code checker: strobes digits, waits for
// the match flag, grants a timed unlock or counts failures up to lockout.
// Ports: clk, reset, insere, numero, chk_ok in; chk_insere, chk_numero,
// chk_reset, unlock, locked, A..G (status digit) out.
module controle_acesso
  import controle_pkg::*;
#(
  parameter int CODE_LEN    = 6,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 20,
  parameter int OPEN_CYCLES = 8,
  parameter int CHK_LAT     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       insere,
  input  logic [4:1] numero,
  input  logic       chk_ok,
  output logic       chk_insere,
  output logic [4:1] chk_numero,
  output logic       chk_reset,
  output logic       unlock,
  output logic       locked,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       E,
  output logic       F,
  output logic       G
);

  localparam int TMAX = max3(LOCK_CYCLES, OPEN_CYCLES, CHK_LAT);
  localparam int TW   = $clog2(TMAX) + 1;

  state_t          state_q, state_d;
  logic            ins_q;
  logic            strobe;
  logic [3:0]      dig_cnt_q, dig_cnt_d;
  logic [3:0]      fail_cnt_q, fail_cnt_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            ci_q, ci_d;
  logic [4:1]      cn_q, cn_d;
  logic            clr_q, unl_q, lck_q;
  logic [3:0]      disp_val;
  logic [6:0]      seg;

  assign strobe = insere & ~ins_q;

  always_comb begin
    state_d    = state_q;
    dig_cnt_d  = dig_cnt_q;
    fail_cnt_d = fail_cnt_q;
    tmr_d      = tmr_q;
    ci_d       = 1'b0;
    cn_d       = cn_q;
    unique case (state_q)
      S_IDLE: begin
        if (strobe) begin
          ci_d      = 1'b1;
          cn_d      = numero;
          dig_cnt_d = dig_cnt_q + 4'd1;
          if (dig_cnt_d == 4'(CODE_LEN)) begin
            state_d = S_WAIT;
            tmr_d   = TW'(CHK_LAT - 1);
          end
        end
      end
      S_WAIT: begin
        if (tmr_q == '0) state_d = S_EVAL;
        else             tmr_d   = tmr_q - 1'b1;
      end
      S_EVAL: begin
        if (chk_ok) begin
          fail_cnt_d = '0;
          state_d    = S_OPEN;
          tmr_d      = TW'(OPEN_CYCLES - 1);
        end else begin
          fail_cnt_d = fail_cnt_q + 4'd1;
          if (fail_cnt_d == 4'(MAX_FAIL)) begin
            state_d = S_LOCKED;
            tmr_d   = TW'(LOCK_CYCLES - 1);
          end else begin
            state_d = S_CLEAR;
          end
        end
      end
      S_OPEN: begin
        if (tmr_q == '0) state_d = S_CLEAR;
        else             tmr_d   = tmr_q - 1'b1;
      end
      S_CLEAR: begin
        dig_cnt_d = '0;
        state_d   = S_IDLE;
      end
      S_LOCKED: begin
        if (tmr_q == '0) begin
          fail_cnt_d = '0;
          state_d    = S_CLEAR;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status flags are registered off the next state so they rise on the
  // edge that enters their state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ins_q      <= 1'b0;
      dig_cnt_q  <= '0;
      fail_cnt_q <= '0;
      tmr_q      <= '0;
      ci_q       <= 1'b0;
      cn_q       <= '0;
      clr_q      <= 1'b0;
      unl_q      <= 1'b0;
      lck_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ins_q      <= insere;
      dig_cnt_q  <= dig_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      tmr_q      <= tmr_d;
      ci_q       <= ci_d;
      cn_q       <= cn_d;
      clr_q      <= (state_d == S_CLEAR);
      unl_q      <= (state_d == S_OPEN);
      lck_q      <= (state_d == S_LOCKED);
    end
  end

  assign chk_insere = ci_q;
  assign chk_numero = cn_q;
  assign chk_reset  = reset | clr_q;
  assign unlock     = unl_q;
  assign locked     = lck_q;

  assign disp_val = 4'(MAX_FAIL) - fail_cnt_q;

  dec7seg u_seg (
    .val_i  (disp_val),
    .lock_i (lck_q),
    .seg_o  (seg)
  );

  assign {A, B, C, D, E, F, G} = seg;

endmodule
